// File: rtl/program_loader.sv
// Boot loader for the BIP I CPU: assembles a byte stream (count header, then
// little-endian 16-bit words) into instruction memory and holds the CPU in reset until done.
module program_loader #(
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 2048
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [7:0]            RxData,
  input  logic                  RxValid,
  input  logic                  Reload,
  input  logic [ADDR_WIDTH-1:0] InsAddr,
  output logic [DATA_WIDTH-1:0] Instruction,
  output logic                  CpuReset,
  output logic                  Loading,
  output logic                  Error,
  output logic [11:0]           WordsLoaded
);

  typedef enum logic [2:0] {
    CNT_LO, CNT_HI, WORD_LO, WORD_HI, RUN, ERROR
  } state_t;

  state_t                  state_q, state_d;
  logic [15:0]             n_q, n_d;
  logic [7:0]              lo_q, lo_d;
  logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic [11:0]             words_q, words_d;
  logic                    cpu_reset_q, loading_q, error_q;
  logic                    we;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic [15:0]             n_hdr;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  assign n_hdr   = {RxData, n_q[7:0]};
  assign wr_data = DATA_WIDTH'({RxData, lo_q});

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    lo_d      = lo_q;
    wr_addr_d = wr_addr_q;
    words_d   = words_q;
    we        = 1'b0;
    if (Reload) begin
      // Reload wins over a simultaneous byte, which is dropped.
      state_d   = CNT_LO;
      wr_addr_d = '0;
      words_d   = '0;
    end else if (RxValid) begin
      case (state_q)
        CNT_LO: begin
          n_d     = {8'h00, RxData};
          state_d = CNT_HI;
        end
        CNT_HI: begin
          n_d = n_hdr;
          if (n_hdr == 16'd0)              state_d = RUN;
          else if (n_hdr > 16'(DEPTH))     state_d = ERROR;
          else                             state_d = WORD_LO;
        end
        WORD_LO: begin
          lo_d    = RxData;
          state_d = WORD_HI;
        end
        WORD_HI: begin
          we        = 1'b1;
          wr_addr_d = wr_addr_q + 1'b1;
          words_d   = words_q + 12'd1;
          state_d   = (16'(words_q) + 16'd1 == n_q) ? RUN : WORD_LO;
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q     <= CNT_LO;
      n_q         <= '0;
      lo_q        <= '0;
      wr_addr_q   <= '0;
      words_q     <= '0;
      cpu_reset_q <= 1'b1;
      loading_q   <= 1'b1;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      lo_q        <= lo_d;
      wr_addr_q   <= wr_addr_d;
      words_q     <= words_d;
      cpu_reset_q <= (state_d != RUN);
      loading_q   <= (state_d == CNT_LO) || (state_d == CNT_HI) ||
                     (state_d == WORD_LO) || (state_d == WORD_HI);
      error_q     <= (state_d == ERROR);
    end
  end

  // Memory is deliberately outside the reset domain so a program survives Reset.
  always_ff @(posedge Clock) begin
    if (we && !Reset) mem[wr_addr_q] <= wr_data;
  end

  assign Instruction = (state_q == RUN) ? mem[InsAddr] : '0;
  assign CpuReset    = cpu_reset_q;
  assign Loading     = loading_q;
  assign Error       = error_q;
  assign WordsLoaded = words_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: byte streams with hand-computed memory and flag expectations.
module tb_program_loader;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic [7:0]  RxData = '0;
  logic        RxValid = 1'b0;
  logic        Reload = 1'b0;
  logic [10:0] InsAddr = '0;
  logic [15:0] Instruction;
  logic        CpuReset, Loading, Error;
  logic [11:0] WordsLoaded;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [7:0]  stream [$];

  program_loader #(.ADDR_WIDTH(11), .DATA_WIDTH(16), .DEPTH(2048)) dut (
    .Clock(Clock), .Reset(Reset), .RxData(RxData), .RxValid(RxValid),
    .Reload(Reload), .InsAddr(InsAddr), .Instruction(Instruction),
    .CpuReset(CpuReset), .Loading(Loading), .Error(Error),
    .WordsLoaded(WordsLoaded)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drives each byte for one rising edge, separated by `gap` idle cycles;
  // returns at the falling edge just after the last byte was accepted.
  task automatic load(input int unsigned gap);
    for (int unsigned i = 0; i < stream.size(); i++) begin
      @(negedge Clock);
      if (i == stream.size() - 1) check("cpurst_before_last", {31'd0, CpuReset}, 32'd1);
      RxValid = 1'b1;
      RxData  = stream[i];
      if (i != stream.size() - 1)
        for (int unsigned g = 0; g < gap; g++) begin
          @(negedge Clock);
          RxValid = 1'b0;
        end
    end
    @(negedge Clock);
    RxValid = 1'b0;
  endtask

  task automatic read(input string tag, input logic [10:0] addr, input logic [15:0] exp);
    InsAddr = addr;
    #1;
    check(tag, {16'd0, Instruction}, {16'd0, exp});
  endtask

  task automatic reload_pulse();
    @(negedge Clock);
    Reload = 1'b1;
    @(negedge Clock);
    Reload = 1'b0;
  endtask

  initial begin
    Reset = 1'b1;
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
    check("rst_cpureset", {31'd0, CpuReset}, 32'd1);
    check("rst_loading", {31'd0, Loading}, 32'd1);
    check("rst_error", {31'd0, Error}, 32'd0);
    check("rst_words", {20'd0, WordsLoaded}, 32'd0);
    check("rst_instr", {16'd0, Instruction}, 32'd0);

    // Two words, back-to-back bytes
    stream = '{8'h02, 8'h00, 8'h55, 8'h18, 8'h01, 8'h00};
    load(0);
    check("b2b_cpureset", {31'd0, CpuReset}, 32'd0);
    check("b2b_loading", {31'd0, Loading}, 32'd0);
    check("b2b_words", {20'd0, WordsLoaded}, 32'd2);
    read("b2b_mem0", 11'd0, 16'h1855);
    read("b2b_mem1", 11'd1, 16'h0001);

    // Same stream with 3 idle cycles between bytes
    reload_pulse();
    check("reload_cpureset", {31'd0, CpuReset}, 32'd1);
    check("reload_instr", {16'd0, Instruction}, 32'd0);
    load(3);
    check("gap_cpureset", {31'd0, CpuReset}, 32'd0);
    check("gap_words", {20'd0, WordsLoaded}, 32'd2);
    read("gap_mem0", 11'd0, 16'h1855);
    read("gap_mem1", 11'd1, 16'h0001);

    // N = 2049 is rejected; later bytes are ignored
    reload_pulse();
    stream = '{8'h01, 8'h08};
    load(0);
    check("err_error", {31'd0, Error}, 32'd1);
    check("err_cpureset", {31'd0, CpuReset}, 32'd1);
    check("err_loading", {31'd0, Loading}, 32'd0);
    stream = '{8'h00, 8'h00};
    load(1);
    check("err_hold_error", {31'd0, Error}, 32'd1);
    check("err_hold_cpureset", {31'd0, CpuReset}, 32'd1);
    check("err_hold_words", {20'd0, WordsLoaded}, 32'd0);
    check("err_hold_instr", {16'd0, Instruction}, 32'd0);
    reload_pulse();
    check("err_clr_error", {31'd0, Error}, 32'd0);
    check("err_clr_loading", {31'd0, Loading}, 32'd1);

    // N = 0: straight to RUN, old contents still visible
    stream = '{8'h00, 8'h00};
    load(0);
    check("n0_cpureset", {31'd0, CpuReset}, 32'd0);
    check("n0_words", {20'd0, WordsLoaded}, 32'd0);
    read("n0_mem0", 11'd0, 16'h1855);
    read("n0_mem1", 11'd1, 16'h0001);

    // Reset after 3 bytes of a 2-word load, then a 1-word load
    reload_pulse();
    stream = '{8'h02, 8'h00, 8'hAA};
    load(0);
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    check("midrst_loading", {31'd0, Loading}, 32'd1);
    check("midrst_words", {20'd0, WordsLoaded}, 32'd0);
    stream = '{8'h01, 8'h00, 8'h34, 8'h12};
    load(0);
    check("midrst_cpureset", {31'd0, CpuReset}, 32'd0);
    check("midrst_words1", {20'd0, WordsLoaded}, 32'd1);
    read("midrst_mem0", 11'd0, 16'h1234);
    read("midrst_mem1", 11'd1, 16'h0001);

    // Reload and a byte in the same cycle during RUN: byte dropped
    @(negedge Clock);
    Reload  = 1'b1;
    RxValid = 1'b1;
    RxData  = 8'h05;
    @(negedge Clock);
    Reload  = 1'b0;
    RxValid = 1'b0;
    #1;
    check("rlrx_cpureset", {31'd0, CpuReset}, 32'd1);
    check("rlrx_instr", {16'd0, Instruction}, 32'd0);
    check("rlrx_loading", {31'd0, Loading}, 32'd1);
    stream = '{8'h01, 8'h00, 8'h77, 8'h66};
    load(0);
    check("rlrx_cpureset_run", {31'd0, CpuReset}, 32'd0);
    read("rlrx_mem0", 11'd0, 16'h6677);

    // Full-depth load, N = 2048
    reload_pulse();
    stream = '{8'h00, 8'h08};
    for (int unsigned k = 0; k < 2048; k++) begin
      stream.push_back(k[7:0]);
      stream.push_back(8'hC0 | {5'd0, k[10:8]});
    end
    load(0);
    check("full_error", {31'd0, Error}, 32'd0);
    check("full_cpureset", {31'd0, CpuReset}, 32'd0);
    check("full_words", {20'd0, WordsLoaded}, 32'd2048);
    read("full_mem0", 11'd0, 16'hC000);
    read("full_mem1", 11'd1, 16'hC001);
    read("full_mem2047", 11'd2047, 16'hC7FF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
